z80_dma_bus_master: RTL and testbench

//  Burst DMA master sharing the Z80 external memory bus with the CPU core. On a start command it

---
 rtl/z80_dma_bus_master.sv | 220 ++++++++++++++++++++++
 tb/tb_z80_dma_bus_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_dma_bus_master.sv
// ============================================================================
// z80_dma_bus_master : burst DMA master that borrows the Z80 memory bus via
//                      BUSRQ/BUSAK and runs byte read/write cycles on it.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module z80_dma_bus_master #(
  parameter int STROBE_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_start,
  input  logic        dma_write,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_len,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_err,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        snk_valid,
  output logic [7:0]  snk_data,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic        bus_own,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  output logic        bus_doe,
  input  logic [7:0]  bus_din,
  output logic        bus_mreq_n,
  output logic        bus_rd_n,
  output logic        bus_wr_n
);

  localparam int             c_scw      = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [c_scw-1:0] c_sc_last = c_scw'(STROBE_CYCLES - 1);
  localparam logic [7:0]     c_tmo_last = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       rem_q, rem_d;
  logic             write_q, write_d;
  logic [7:0]       timer_q, timer_d;
  logic [c_scw-1:0] scnt_q, scnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             src_ready_q, src_ready_d;
  logic             snk_valid_q, snk_valid_d;
  logic [7:0]       snk_data_q, snk_data_d;
  logic             busrq_n_q, busrq_n_d;
  logic             bus_own_q, bus_own_d;
  logic [15:0]      bus_a_q, bus_a_d;
  logic [7:0]       bus_dout_q, bus_dout_d;
  logic             bus_doe_q, bus_doe_d;
  logic             mreq_n_q, mreq_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    write_d     = write_q;
    timer_d     = timer_q;
    scnt_d      = scnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    snk_valid_d = 1'b0;
    snk_data_d  = snk_data_q;
    bus_dout_d  = bus_dout_q;
    bus_a_d     = bus_a_q;

    case (state_q)
      ST_IDLE: begin
        if (dma_start) begin
          addr_d  = dma_addr;
          rem_d   = dma_len;
          write_d = dma_write;
          timer_d = 8'd0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!busak_n) begin
          state_d = ST_SETUP;
        end else if (timer_q == c_tmo_last) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_SETUP: begin
        if (!write_q) begin
          scnt_d  = '0;
          state_d = ST_STROBE;
        end else if (src_valid && src_ready_q) begin
          bus_dout_d = src_data;
          scnt_d     = '0;
          state_d    = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (scnt_q == c_sc_last) begin
          state_d = ST_HOLD;
          if (!write_q) begin
            snk_data_d  = bus_din;
            snk_valid_d = 1'b1;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        addr_d  = addr_q + 16'd1;
        rem_d   = rem_q - 8'd1;
        // len=0 starts at 0 and wraps to 255, giving a 256-byte burst
        state_d = (rem_q != 8'd1) ? ST_SETUP : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (busak_n) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus-facing outputs are decoded from the next state so they leave flops.
    busy_d      = (state_d != ST_IDLE);
    bus_own_d   = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    busrq_n_d   = !(bus_own_d || (state_d == ST_REQ));
    bus_doe_d   = bus_own_d && write_d;
    mreq_n_d    = (state_d != ST_STROBE);
    rd_n_d      = !((state_d == ST_STROBE) && !write_d);
    wr_n_d      = !((state_d == ST_STROBE) && write_d);
    src_ready_d = (state_d == ST_SETUP) && write_d;
    if (state_d == ST_SETUP) begin
      bus_a_d = addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 16'd0;
      rem_q       <= 8'd0;
      write_q     <= 1'b0;
      timer_q     <= 8'd0;
      scnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      src_ready_q <= 1'b0;
      snk_valid_q <= 1'b0;
      snk_data_q  <= 8'd0;
      busrq_n_q   <= 1'b1;
      bus_own_q   <= 1'b0;
      bus_a_q     <= 16'd0;
      bus_dout_q  <= 8'd0;
      bus_doe_q   <= 1'b0;
      mreq_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      write_q     <= write_d;
      timer_q     <= timer_d;
      scnt_q      <= scnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      src_ready_q <= src_ready_d;
      snk_valid_q <= snk_valid_d;
      snk_data_q  <= snk_data_d;
      busrq_n_q   <= busrq_n_d;
      bus_own_q   <= bus_own_d;
      bus_a_q     <= bus_a_d;
      bus_dout_q  <= bus_dout_d;
      bus_doe_q   <= bus_doe_d;
      mreq_n_q    <= mreq_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign dma_busy   = busy_q;
  assign dma_done   = done_q;
  assign dma_err    = err_q;
  assign src_ready  = src_ready_q;
  assign snk_valid  = snk_valid_q;
  assign snk_data   = snk_data_q;
  assign busrq_n    = busrq_n_q;
  assign bus_own    = bus_own_q;
  assign bus_a      = bus_a_q;
  assign bus_dout   = bus_dout_q;
  assign bus_doe    = bus_doe_q;
  assign bus_mreq_n = mreq_n_q;
  assign bus_rd_n   = rd_n_q;
  assign bus_wr_n   = wr_n_q;

endmodule

`default_nettype wire

// File: tb/tb_z80_dma_bus_master.sv
// ============================================================================
// tb_z80_dma_bus_master : directed self-checking bench for z80_dma_bus_master.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z80_dma_bus_master;

  logic        clk;
  logic        rst_n;
  logic        dma_start;
  logic        dma_write;
  logic [15:0] dma_addr;
  logic [7:0]  dma_len;
  logic        dma_busy;
  logic        dma_done;
  logic        dma_err;
  logic        src_valid;
  logic [7:0]  src_data;
  logic        src_ready;
  logic        snk_valid;
  logic [7:0]  snk_data;
  logic        busrq_n;
  logic        busak_n;
  logic        bus_own;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_doe;
  logic [7:0]  bus_din;
  logic        bus_mreq_n;
  logic        bus_rd_n;
  logic        bus_wr_n;

  int n_cmp = 0;
  int n_bad = 0;

  z80_dma_bus_master #(
    .STROBE_CYCLES(2),
    .ACK_TIMEOUT  (255)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dma_start (dma_start),
    .dma_write (dma_write),
    .dma_addr  (dma_addr),
    .dma_len   (dma_len),
    .dma_busy  (dma_busy),
    .dma_done  (dma_done),
    .dma_err   (dma_err),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .snk_valid (snk_valid),
    .snk_data  (snk_data),
    .busrq_n   (busrq_n),
    .busak_n   (busak_n),
    .bus_own   (bus_own),
    .bus_a     (bus_a),
    .bus_dout  (bus_dout),
    .bus_doe   (bus_doe),
    .bus_din   (bus_din),
    .bus_mreq_n(bus_mreq_n),
    .bus_rd_n  (bus_rd_n),
    .bus_wr_n  (bus_wr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  rd_bytes [3];
    logic [15:0] exp_a;
    logic [15:0] prev_a;
    logic        prev_mreq;
    int          bad, pulses, dones, aerr, derr, cyc;

    rd_bytes[0] = 8'h11;
    rd_bytes[1] = 8'h22;
    rd_bytes[2] = 8'h33;

    rst_n = 1'b0; dma_start = 1'b0; dma_write = 1'b0; dma_addr = 16'd0; dma_len = 8'd0;
    src_valid = 1'b0; src_data = 8'd0; busak_n = 1'b1; bus_din = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ---------------- reset state ----------------
    check("rst_busrq_n", 32'(busrq_n), 1);
    check("rst_bus_own", 32'(bus_own), 0);
    check("rst_strobes", 32'({bus_mreq_n, bus_rd_n, bus_wr_n}), 32'b111);
    check("rst_doe",     32'(bus_doe), 0);
    check("rst_flags",   32'({dma_busy, dma_done, dma_err, src_ready, snk_valid}), 0);
    check("rst_data",    32'({bus_a, bus_dout, snk_data}), 0);

    // ---------------- T1: read len=3 @1000 ----------------
    dma_write = 1'b0; dma_addr = 16'h1000; dma_len = 8'd3; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    check("t1_busy", 32'(dma_busy), 1);
    check("t1_busrq", 32'(busrq_n), 0);
    tick();
    check("t1_no_own_in_req", 32'(bus_own), 0);
    tick();
    busak_n = 1'b0;
    tick();
    check("t1_own", 32'(bus_own), 1);
    for (int i = 0; i < 3; i++) begin
      check("t1_setup_a", 32'(bus_a), 32'h1000 + i);
      check("t1_setup_strobes", 32'({bus_mreq_n, bus_rd_n, bus_wr_n}), 32'b111);
      bus_din = rd_bytes[i];
      if (i == 1) begin
        dma_start = 1'b1; dma_addr = 16'h5555; dma_len = 8'd9;
      end
      tick();
      dma_start = 1'b0;
      check("t1_strobe1", 32'({bus_mreq_n, bus_rd_n, bus_wr_n}), 32'b001);
      tick();
      check("t1_strobe2", 32'({bus_mreq_n, bus_rd_n, bus_wr_n}), 32'b001);
      tick();
      check("t1_hold_strobes", 32'({bus_mreq_n, bus_rd_n, bus_wr_n}), 32'b111);
      check("t1_hold_a", 32'(bus_a), 32'h1000 + i);
      check("t1_snk_valid", 32'(snk_valid), 1);
      check("t1_snk_data", 32'(snk_data), 32'(rd_bytes[i]));
      tick();
      check("t1_snk_pulse_end", 32'(snk_valid), 0);
    end
    check("t1_release_own", 32'(bus_own), 0);
    check("t1_release_busrq", 32'(busrq_n), 1);
    check("t1_release_busy", 32'(dma_busy), 1);
    tick();
    check("t1_wait_busak", 32'({dma_busy, dma_done}), 32'b10);
    busak_n = 1'b1;
    tick();
    check("t1_done", 32'({dma_busy, dma_done}), 32'b01);
    tick();
    check("t1_done_pulse", 32'(dma_done), 0);

    // ---------------- T2: write len=2 @FFFF with src stall ----------------
    dma_write = 1'b1; dma_addr = 16'hFFFF; dma_len = 8'd2; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    busak_n = 1'b0;
    tick();
    check("t2_setup_a", 32'(bus_a), 32'hFFFF);
    check("t2_setup_doe", 32'(bus_doe), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall", 32'({bus_own, src_ready, bus_mreq_n, bus_wr_n}), 32'b1111);
    end
    src_valid = 1'b1; src_data = 8'hA5;
    tick();
    src_valid = 1'b0;
    check("t2_consumed", 32'(src_ready), 0);
    check("t2_strobe1", 32'({bus_mreq_n, bus_rd_n, bus_wr_n}), 32'b010);
    check("t2_dout0", 32'(bus_dout), 32'hA5);
    tick();
    check("t2_strobe2", 32'({bus_mreq_n, bus_rd_n, bus_wr_n}), 32'b010);
    tick();
    check("t2_hold", 32'({bus_mreq_n, bus_wr_n, bus_doe, snk_valid}), 32'b1110);
    check("t2_hold_dout", 32'({bus_a, bus_dout}), 32'hFFFF_A5);
    tick();
    check("t2_wrap_a", 32'(bus_a), 32'h0000);
    check("t2_setup2_ready", 32'({src_ready, bus_wr_n}), 32'b11);
    src_valid = 1'b1; src_data = 8'h3C;
    tick();
    src_valid = 1'b0;
    check("t2_strobe_b2", 32'({bus_mreq_n, bus_rd_n, bus_wr_n}), 32'b010);
    check("t2_dout1", 32'(bus_dout), 32'h3C);
    tick();
    tick();
    tick();
    check("t2_release", 32'({bus_own, bus_doe, busrq_n}), 32'b001);
    busak_n = 1'b1;
    tick();
    check("t2_done", 32'({dma_busy, dma_done}), 32'b01);

    // ---------------- T3: BUSAK timeout ----------------
    dma_write = 1'b0; dma_addr = 16'h4000; dma_len = 8'd1; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (busrq_n !== 1'b0 || bus_mreq_n !== 1'b1 || dma_err !== 1'b0 || bus_own !== 1'b0) bad++;
    end
    check("t3_req_window", 32'(bad), 0);
    tick();
    check("t3_abort", 32'({busrq_n, dma_err, dma_busy, bus_mreq_n}), 32'b1101);
    tick();
    check("t3_err_pulse", 32'({dma_err, dma_done}), 0);

    // ---------------- T4: len=0 -> 256 bytes, address wrap ----------------
    busak_n = 1'b0;
    dma_write = 1'b0; dma_addr = 16'hFF80; dma_len = 8'd0; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    pulses = 0; dones = 0; aerr = 0; derr = 0; cyc = 0;
    exp_a = 16'hFF80; prev_mreq = 1'b1;
    while (cyc < 2000 && !(dones > 0 && !dma_busy)) begin
      tick();
      cyc++;
      if (busrq_n && dma_busy) busak_n = 1'b1;
      if (!bus_mreq_n && prev_mreq) begin
        if (bus_a !== exp_a) aerr++;
        exp_a = exp_a + 16'd1;
      end
      prev_mreq = bus_mreq_n;
      if (snk_valid) begin
        pulses++;
        prev_a = exp_a - 16'd1;
        if (snk_data !== prev_a[7:0]) derr++;
      end
      if (dma_done) dones++;
      bus_din = bus_a[7:0];
    end
    check("t4_finished", 32'(dma_busy), 0);
    check("t4_byte_count", 32'(pulses), 256);
    check("t4_addr_seq_errs", 32'(aerr), 0);
    check("t4_data_errs", 32'(derr), 0);
    check("t4_next_addr", 32'(exp_a), 32'h0080);
    check("t4_last_a", 32'(bus_a), 32'h007F);
    repeat (3) begin
      tick();
      if (dma_done) dones++;
    end
    check("t4_single_done", 32'(dones), 1);

    // ---------------- T5: async reset mid-STROBE ----------------
    busak_n = 1'b0;
    dma_write = 1'b0; dma_addr = 16'h2000; dma_len = 8'd4; dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    tick();
    tick();
    check("t5_in_strobe", 32'({bus_mreq_n, bus_rd_n}), 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_reset_release", 32'({busrq_n, bus_own, bus_mreq_n, bus_rd_n, bus_wr_n}), 32'b10111);
    check("t5_reset_flags", 32'({dma_busy, dma_done, dma_err}), 0);
    busak_n = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    check("t5_idle_no_pulse", 32'({dma_busy, dma_done, dma_err}), 0);
    dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    check("t5_restart", 32'({dma_busy, busrq_n}), 32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
